// File: rtl/cell_redraw_ctl.sv
// -----------------------------------------------------------------------------
// cell_redraw_ctl
//
// Purpose
//   Paces the board scan counter and decides which cells must be redrawn.
//   Each scanned cell is captured from the scan indices. One cycle later its
//   board-memory state is compared against a shadow copy of what was last
//   drawn. A redraw request is queued when the state differs, or
//   unconditionally during the full pass that follows a level change. Queued
//   requests are handed to the cell drawer over a valid/ready handshake.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   level[1:0]     game level; 0 = no board, 1-3 = active board
//   button_num     board dimension in cells per side (1..MAX_DIM)
//   arr_x_refresh  scan column from the scan counter
//   arr_y_refresh  scan row from the scan counter
//   counting       advance enable back to the scan counter
//   mem_addr       board memory read address {row, column}, combinational
//   mem_data       board memory read data, one cycle after mem_addr
//   req_valid      redraw request valid (request queue non-empty)
//   req_ready      drawer accepts the head request
//   req_x, req_y   cell coordinates of the head request
//   req_state      cell state to draw
//   redraw_cnt     (REDRAW_STATS_EN only) pushes made in the last complete pass
//
// Configuration
//   REDRAW_STATS_EN : when defined, adds the redraw_cnt output and its counter.
//
// FIFO_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module cell_redraw_ctl #(
   parameter int MAX_DIM    = 16,
   parameter int STATE_W    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         level,
   input  logic [4:0]         button_num,
   input  logic [4:0]         arr_x_refresh,
   input  logic [4:0]         arr_y_refresh,
   output logic               counting,
   output logic [9:0]         mem_addr,
   input  logic [STATE_W-1:0] mem_data,
   output logic               req_valid,
   input  logic               req_ready,
   output logic [4:0]         req_x,
   output logic [4:0]         req_y,
   output logic [STATE_W-1:0] req_state
`ifdef REDRAW_STATS_EN
   ,
   output logic [9:0]         redraw_cnt
`endif
);

   localparam int IDX_W    = $clog2(MAX_DIM);
   // Shadow is indexed by {y, x} truncated to IDX_W bits each; for a
   // power-of-two MAX_DIM this is exactly MAX_DIM*MAX_DIM entries.
   localparam int SH_DEPTH = 2 ** (2 * IDX_W);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = AW + 1;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_ORIGIN,
      ST_FULL_PASS,
      ST_DELTA
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [1:0]         level_q, level_d;
   logic               s1_valid_q, s1_valid_d;
   logic [4:0]         s1_x_q, s1_x_d;
   logic [4:0]         s1_y_q, s1_y_d;

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [4:0]         fifo_x_mem  [FIFO_DEPTH];
   logic [4:0]         fifo_y_mem  [FIFO_DEPTH];
   logic [STATE_W-1:0] fifo_st_mem [FIFO_DEPTH];

   logic [STATE_W-1:0] shadow_mem  [SH_DEPTH];
   logic [STATE_W-1:0] shadow_rd_q;

   logic               push;
   logic               pop;
   logic               flush;
   logic               at_origin;
   logic               at_pass_end;
   logic               cell_changed;
   logic [4:0]         last_idx;
   logic [CNT_W:0]     occupancy;
   logic [2*IDX_W-1:0] cap_idx;
   logic [2*IDX_W-1:0] s1_idx;

   assign mem_addr = {arr_y_refresh, arr_x_refresh};

   assign cap_idx  = {arr_y_refresh[IDX_W-1:0], arr_x_refresh[IDX_W-1:0]};
   assign s1_idx   = {s1_y_q[IDX_W-1:0], s1_x_q[IDX_W-1:0]};

   // button_num=0 is illegal, so the 5-bit wrap of button_num-1 is harmless.
   assign last_idx    = button_num - 5'd1;
   assign at_origin   = s1_valid_q && (s1_x_q == 5'd0) && (s1_y_q == 5'd0);
   assign at_pass_end = s1_valid_q && (s1_x_q == last_idx) && (s1_y_q == last_idx);
   assign cell_changed = (mem_data != shadow_rd_q);

   // Entries already queued plus the one in flight in s1 must leave room,
   // so a push can never meet a full queue.
   assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
   assign counting  = (level != 2'd0) && (state_q != ST_IDLE) && (occupancy < DEPTH_L);

   // ---------------------------------------------------------------------
   // FSM, capture stage and push decision
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      level_d    = level;
      s1_valid_d = counting;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      push       = 1'b0;
      flush      = 1'b0;

      if (counting) begin
         s1_x_d = arr_x_refresh;
         s1_y_d = arr_y_refresh;
      end

      case (state_q)
         ST_IDLE: begin
            if (level != 2'd0) begin
               state_d = ST_WAIT_ORIGIN;
            end
         end
         ST_WAIT_ORIGIN: begin
            // The origin cell itself opens the full pass and is drawn.
            if (at_origin) begin
               push    = 1'b1;
               state_d = at_pass_end ? ST_DELTA : ST_FULL_PASS;
            end
         end
         ST_FULL_PASS: begin
            if (s1_valid_q) begin
               push = 1'b1;
               if (at_pass_end) begin
                  state_d = ST_DELTA;
               end
            end
         end
         ST_DELTA: begin
            if (s1_valid_q && cell_changed) begin
               push = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Board removal and level changes override everything above; the cell
      // in flight belongs to the old board and is discarded.
      if (level == 2'd0) begin
         state_d    = ST_IDLE;
         flush      = 1'b1;
         push       = 1'b0;
         s1_valid_d = 1'b0;
      end else if (level != level_q) begin
         state_d    = ST_WAIT_ORIGIN;
         flush      = 1'b1;
         push       = 1'b0;
         s1_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Request queue control
   // ---------------------------------------------------------------------
   assign req_valid = (count_q != {CNT_W{1'b0}});
   assign pop       = req_valid && req_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end
         count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
      end
   end

   // Storage is not reset, so the head is masked while the queue is empty;
   // this keeps the payload at zero out of reset and after a flush.
   assign req_x     = req_valid ? fifo_x_mem[rd_ptr_q]  : 5'd0;
   assign req_y     = req_valid ? fifo_y_mem[rd_ptr_q]  : 5'd0;
   assign req_state = req_valid ? fifo_st_mem[rd_ptr_q] : {STATE_W{1'b0}};

   // ---------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         level_q    <= 2'd0;
         s1_valid_q <= 1'b0;
         s1_x_q     <= 5'd0;
         s1_y_q     <= 5'd0;
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         count_q    <= {CNT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         s1_valid_q <= s1_valid_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // ---------------------------------------------------------------------
   // Storage: request queue and shadow of drawn states
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_x_mem[wr_ptr_q]  <= s1_x_q;
         fifo_y_mem[wr_ptr_q]  <= s1_y_q;
         fifo_st_mem[wr_ptr_q] <= mem_data;
      end
   end

   // The shadow is read at capture time so its value lines up with mem_data
   // in the compare cycle. A write to the very cell being captured (only
   // possible on a 1x1 board) is forwarded so the compare sees fresh data.
   always_ff @(posedge clk) begin
      if (push) begin
         shadow_mem[s1_idx] <= mem_data;
      end
      if (counting) begin
         if (push && (s1_idx == cap_idx)) begin
            shadow_rd_q <= mem_data;
         end else begin
            shadow_rd_q <= shadow_mem[cap_idx];
         end
      end
   end

`ifdef REDRAW_STATS_EN
   // ---------------------------------------------------------------------
   // Per-pass redraw statistics
   // ---------------------------------------------------------------------
   logic [9:0] stat_cnt_q, stat_cnt_d;
   logic [9:0] redraw_cnt_q, redraw_cnt_d;
   logic [9:0] stat_inc;

   assign stat_inc = (stat_cnt_q == 10'd1023) ? 10'd1023
                                               : stat_cnt_q + {9'd0, push};

   always_comb begin
      stat_cnt_d   = stat_inc;
      redraw_cnt_d = redraw_cnt_q;
      if (flush) begin
         stat_cnt_d = 10'd0;
      end else if (at_pass_end) begin
         // The last cell's own push is part of the pass being reported.
         redraw_cnt_d = stat_inc;
         stat_cnt_d   = 10'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_cnt_q   <= 10'd0;
         redraw_cnt_q <= 10'd0;
      end else begin
         stat_cnt_q   <= stat_cnt_d;
         redraw_cnt_q <= redraw_cnt_d;
      end
   end

   assign redraw_cnt = redraw_cnt_q;
`endif

endmodule

// File: tb/tb_cell_redraw_ctl.sv
// -----------------------------------------------------------------------------
// tb_cell_redraw_ctl
//
// Drives cell_redraw_ctl with a scan-counter model and a board memory with a
// one-cycle registered read. Expected redraw requests are queued when each
// stimulus phase starts; a negedge monitor pops and compares each handshake.
// -----------------------------------------------------------------------------
module tb_cell_redraw_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] level;
   logic [4:0] button_num;
   logic [4:0] arr_x_refresh;
   logic [4:0] arr_y_refresh;
   logic       counting;
   logic [9:0] mem_addr;
   logic [3:0] mem_data;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] req_x;
   logic [4:0] req_y;
   logic [3:0] req_state;
`ifdef REDRAW_STATS_EN
   logic [9:0] redraw_cnt;
`endif

   cell_redraw_ctl #(
      .MAX_DIM    (16),
      .STATE_W    (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .level         (level),
      .button_num    (button_num),
      .arr_x_refresh (arr_x_refresh),
      .arr_y_refresh (arr_y_refresh),
      .counting      (counting),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_x         (req_x),
      .req_y         (req_y),
      .req_state     (req_state)
`ifdef REDRAW_STATS_EN
      ,
      .redraw_cnt    (redraw_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] x;
      logic [4:0] y;
      logic [3:0] st;
   } req_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pops   = 0;
   req_t exp_q[$];
   logic [3:0] board [0:255];

   // Scan counter model: row-major, wraps at button_num.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         arr_x_refresh <= 5'd0;
         arr_y_refresh <= 5'd0;
      end else if (counting) begin
         if (arr_x_refresh == button_num - 5'd1) begin
            arr_x_refresh <= 5'd0;
            arr_y_refresh <= (arr_y_refresh == button_num - 5'd1) ? 5'd0 : arr_y_refresh + 5'd1;
         end else begin
            arr_x_refresh <= arr_x_refresh + 5'd1;
         end
      end
   end

   // Board memory, registered read.
   always @(posedge clk) begin
      mem_data <= board[{mem_addr[8:5], mem_addr[3:0]}];
   end

   // Monitor / scoreboard.
   logic hold_valid = 1'b0;
   req_t hold;
   always @(negedge clk) begin
      if (rst) begin
         hold_valid = 1'b0;
      end else begin
         if (hold_valid && req_valid) begin
            n_checks++;
            if ({req_x, req_y, req_state} != hold) begin
               n_fail++;
               $display("FAIL payload_stable got x=%0d y=%0d st=%0d required x=%0d y=%0d st=%0d",
                        req_x, req_y, req_state, hold.x, hold.y, hold.st);
            end
         end
         if (req_valid && req_ready) begin
            n_pops++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_req got x=%0d y=%0d st=%0d required none",
                        req_x, req_y, req_state);
            end else begin
               req_t e;
               e = exp_q.pop_front();
               if (req_x !== e.x || req_y !== e.y || req_state !== e.st) begin
                  n_fail++;
                  $display("FAIL req_%0d got x=%0d y=%0d st=%0d required x=%0d y=%0d st=%0d",
                           n_pops, req_x, req_y, req_state, e.x, e.y, e.st);
               end else begin
                  $display("req %0d x=%0d y=%0d st=%0d ok", n_pops, req_x, req_y, req_state);
               end
            end
            hold_valid = 1'b0;
         end else if (req_valid) begin
            hold_valid = 1'b1;
            hold       = {req_x, req_y, req_state};
         end else begin
            hold_valid = 1'b0;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic drain(input string name, input int budget);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         cyc(1);
         i++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic push_pass(input int dim);
      for (int y = 0; y < dim; y++) begin
         for (int x = 0; x < dim; x++) begin
            req_t e;
            e.x  = 5'(x);
            e.y  = 5'(y);
            e.st = board[y * 16 + x];
            exp_q.push_back(e);
         end
      end
   endtask

   initial begin
      int k;
      for (int i = 0; i < 256; i++) board[i] = 4'd0;
      rst        = 1'b1;
      level      = 2'd0;
      button_num = 5'd8;
      req_ready  = 1'b0;
      cyc(3);

      // Reset state
      chk("rst_counting",  counting,  0);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_req_x",     req_x,     0);
      chk("rst_req_y",     req_y,     0);
      chk("rst_req_state", req_state, 0);
      rst = 1'b0;
      cyc(2);

      // Full pass on an all-zero 8x8 board
      req_ready = 1'b1;
      push_pass(8);
      level = 2'd1;
      drain("full_pass_8x8", 400);
`ifdef REDRAW_STATS_EN
      chk("stats_full_pass", redraw_cnt, 64);
`endif
      cyc(200);
      chk("full_pass_count_then_quiet", n_pops, 64);

      // Two changes made while the scan is in the last row -> next frame
      k = 0;
      while (arr_y_refresh != 5'd7 && k < 200) begin
         cyc(1);
         k++;
      end
      chk("scan_reaches_row7", arr_y_refresh, 7);
      board[5 * 16 + 3] = 4'h9;
      board[2 * 16 + 6] = 4'h3;
      exp_q.push_back({5'd6, 5'd2, 4'h3});
      exp_q.push_back({5'd3, 5'd5, 4'h9});
      drain("delta_two_changes", 300);
`ifdef REDRAW_STATS_EN
      cyc(30);
      chk("stats_delta", redraw_cnt, 2);
`endif
      cyc(200);
      chk("delta_count_then_quiet", n_pops, 66);

      // Level change with backpressure: queue fills, scanning stalls
      req_ready = 1'b0;
      level     = 2'd2;
      push_pass(8);
      cyc(120);
      chk("bp_counting_low", counting,  0);
      chk("bp_req_valid",    req_valid, 1);
      chk("bp_head_x",       req_x,     0);
      chk("bp_head_y",       req_y,     0);
      req_ready = 1'b1;
      drain("bp_full_pass", 400);
      cyc(20);
      chk("bp_count", n_pops, 130);

      // Queued delta request is flushed by a level + size change
      req_ready = 1'b0;
      board[1 * 16 + 1] = 4'h2;
      cyc(100);
      chk("pending_valid",  req_valid, 1);
      chk("pending_head_x", req_x,     1);
      chk("pending_head_y", req_y,     1);
      chk("pending_state",  req_state, 2);
      level      = 2'd3;
      button_num = 5'd16;
      cyc(1);
      chk("flush_on_level_change", req_valid, 0);
      push_pass(16);
      req_ready = 1'b1;
      drain("full_pass_16x16", 1500);
      cyc(20);
      chk("full_pass_16_count", n_pops, 386);

      // Board removal
      req_ready = 1'b0;
      board[2 * 16 + 2] = 4'h5;
      cyc(300);
      chk("pre_off_valid",  req_valid, 1);
      chk("pre_off_head_x", req_x,     2);
      chk("pre_off_state",  req_state, 5);
      level = 2'd0;
      #1;
      chk("off_counting", counting, 0);
      cyc(1);
      chk("off_req_valid", req_valid, 0);

      // Asynchronous reset in the middle of a pass
      level = 2'd1;
      cyc(400);
      chk("midpass_valid",    req_valid, 1);
      chk("midpass_counting", counting,  0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_counting",  counting,  0);
      chk("async_rst_req_valid", req_valid, 0);
      chk("async_rst_req_x",     req_x,     0);
      chk("async_rst_req_y",     req_y,     0);
      chk("async_rst_req_state", req_state, 0);
      cyc(2);
      rst = 1'b0;
      level = 2'd0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
